pipe_hazard_unit: RTL and testbench
===================================

Name: pipe_hazard_unit

Overview:
- Parametrised successor to the 5-stage pipeline control unit's hazard and forwarding logic.
- Sits beside the ID stage and generates forwarding selects for ALU operands A and B, PC/IR write-enable, EXE bubble and IF flush.
- Adds three things the previous generation lacked: load-use stall, branch-operand stall for ID-stage compare, and a scoreboard for a multi-cycle multiplier with a configurable latency.

Parameters:
- REG_ADDR_W, 5, width of register specifiers.
- MUL_LAT, 4, multiplier latency in cycles (>=2); result is writable/forwardable from MEM after this many cycles.
- CNT_W, 3, width of the multiplier countdown; must hold MUL_LAT-1.
- PERF_W, 32, width of the stall counter (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- d_rs, d_rt  in  REG_ADDR_W  ID-stage source registers
- d_use_rs, d_use_rt  in  1  ID instruction actually reads rs / rt
- d_is_branch  in  1  ID holds a conditional branch
- d_branch_ne  in  1  1 = bne, 0 = beq
- rs_rt_equ  in  1  forwarded rs == rt compare from ID
- d_is_mul  in  1  ID holds a multiply
- d_des  in  REG_ADDR_W  ID destination register
- e_des, m_des  in  REG_ADDR_W  EXE / MEM destination registers
- e_write_reg, m_write_reg  in  1  EXE / MEM write the register file
- e_mem_to_reg, m_mem_to_reg  in  1  EXE / MEM instruction is a load
- fwd_a, fwd_b  out  2  forwarding select: 00 regfile, 01 EXE ALU result, 10 MEM ALU result, 11 MEM load data
- write_pc_ir  out  1  1 = PC and IF/ID advance
- bubble  out  1  insert NOP into ID/EXE
- flush_if  out  1  squash IF/ID (taken branch)
- mul_busy  out  1  multiplier occupied
- stall_cycles  out  PERF_W  stall count (optional feature; 0 when compiled out)

Behaviour:
- Register 0 never produces a hazard or a forward.
- A source "matches" a stage when the source is used, the stage's write_reg is 1, and des equals the source (nonzero).
- fwd_x, combinational; priority EXE over MEM:
  - EXE match with e_mem_to_reg=0 -> 01.
  - Else MEM match -> 11 if m_mem_to_reg, else 10.
  - Else 00.
- load_use = EXE match on rs or rt with e_mem_to_reg=1.
- br_dep = d_is_branch and EXE match on rs or rt; the ID compare cannot see EXE results.
- Multiplier scoreboard:
  - Registers mul_cnt[CNT_W] and mul_des[REG_ADDR_W]; state RUN (mul_cnt=0) or MUL_WAIT (mul_cnt>0).
  - mul_dep = MUL_WAIT and (d_is_mul, or rs/rt used and equal to mul_des, or d_write_reg-style overwrite of mul_des by d_des).
  - RUN: d_is_mul and no stall -> mul_cnt=MUL_LAT-1, mul_des=d_des, enter MUL_WAIT.
  - MUL_WAIT: decrement each cycle; at 1 -> 0, back to RUN.
  - A new mul is accepted in the cycle mul_cnt reaches 0, not earlier.
- stall = load_use | br_dep | mul_dep:
  - write_pc_ir = ~stall; bubble = stall.
  - A stalled mul does not load the scoreboard.
- taken = d_is_branch & (d_branch_ne ? ~rs_rt_equ : rs_rt_equ).
- flush_if = taken & ~stall; stall wins when both occur in the same cycle.
- mul_busy = (mul_cnt != 0), registered.
- Reset (synchronous):
  - mul_cnt=0, mul_des=0, stall_cycles=0.
  - While rst=1: fwd_a=fwd_b=00, write_pc_ir=1, bubble=0, flush_if=0, mul_busy=0.
  - Reset mid-multiply abandons the scoreboard entry; the next cycle is RUN.
- All state changes occur on the rising edge of clk only.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: stall_cycles increments every cycle with stall=1 and rst=0, saturates at all-ones, and clears on rst.
- Undefined: the counter is not built and stall_cycles is tied to 0.
- Hazard behaviour is identical either way.

Test Plan:
- EXE ALU forward: e_des=3, e_write_reg=1, e_mem_to_reg=0; m_des=3, m_write_reg=1; d_rs=3 used -> fwd_a=01, write_pc_ir=1, bubble=0.
- Load-use: e_des=5, e_mem_to_reg=1, e_write_reg=1; d_rt=5 used -> one cycle write_pc_ir=0, bubble=1. Next cycle, with m_des=5, m_mem_to_reg=1 -> fwd_b=11, no stall.
- Register 0 guard: e_des=0, e_write_reg=1; d_rs=0 used -> fwd_a=00, no stall.
- Branch: d_is_branch=1, d_branch_ne=0, rs_rt_equ=1, no deps -> flush_if=1. Repeat with e_des=d_rs -> flush_if=0, stall=1 for 1 cycle, then flush_if=1.
- Multiply, MUL_LAT=4: mul to r7 at cycle 0 -> mul_busy=1 for cycles 1-3. Instruction reading r7 at cycle 1 stalls cycles 1-3 and proceeds at cycle 4. A second mul also stalls until cycle 4.
- Reset mid-multiply: assert rst at cycle 2 of a mul -> next cycle mul_busy=0, write_pc_ir=1. With HAZARD_PERF_EN defined, stall_cycles=0 after reset, and 3 after the multiply-dependency scenario.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - ID-stage forwarding, stall, flush and multiplier scoreboard
// Optional stall counter built only when HAZARD_PERF_EN is defined.
module pipe_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int MUL_LAT    = 4,
  parameter int CNT_W      = 3,
  parameter int PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] d_rs,
  input  logic [REG_ADDR_W-1:0] d_rt,
  input  logic                  d_use_rs,
  input  logic                  d_use_rt,
  input  logic                  d_is_branch,
  input  logic                  d_branch_ne,
  input  logic                  rs_rt_equ,
  input  logic                  d_is_mul,
  input  logic [REG_ADDR_W-1:0] d_des,
  input  logic [REG_ADDR_W-1:0] e_des,
  input  logic [REG_ADDR_W-1:0] m_des,
  input  logic                  e_write_reg,
  input  logic                  m_write_reg,
  input  logic                  e_mem_to_reg,
  input  logic                  m_mem_to_reg,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  write_pc_ir,
  output logic                  bubble,
  output logic                  flush_if,
  output logic                  mul_busy,
  output logic [PERF_W-1:0]     stall_cycles
);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        mul_cnt;
  logic [REG_ADDR_W-1:0]   mul_des;

  logic rs_nz, rt_nz, des_nz;
  logic e_match_rs, e_match_rt, m_match_rs, m_match_rt;
  logic load_use, br_dep, mul_dep, stall, taken;

  assign rs_nz  = (d_rs  != '0);
  assign rt_nz  = (d_rt  != '0);
  assign des_nz = (d_des != '0);

  // A zero specifier never matches, so r0 can neither forward nor stall.
  assign e_match_rs = d_use_rs & e_write_reg & rs_nz & (e_des == d_rs);
  assign e_match_rt = d_use_rt & e_write_reg & rt_nz & (e_des == d_rt);
  assign m_match_rs = d_use_rs & m_write_reg & rs_nz & (m_des == d_rs);
  assign m_match_rt = d_use_rt & m_write_reg & rt_nz & (m_des == d_rt);

  assign load_use = (e_match_rs | e_match_rt) & e_mem_to_reg;
  assign br_dep   = d_is_branch & (e_match_rs | e_match_rt);

  assign mul_dep = (state == MUL_WAIT) &
                   (d_is_mul |
                    (d_use_rs & rs_nz & (d_rs == mul_des)) |
                    (d_use_rt & rt_nz & (d_rt == mul_des)) |
                    (des_nz & (d_des == mul_des)));

  assign stall = (load_use | br_dep | mul_dep) & ~rst;
  assign taken = d_is_branch & (d_branch_ne ? ~rs_rt_equ : rs_rt_equ);

  always_comb begin
    fwd_a = 2'b00;
    if (!rst) begin
      if (e_match_rs && !e_mem_to_reg) fwd_a = 2'b01;
      else if (m_match_rs)             fwd_a = m_mem_to_reg ? 2'b11 : 2'b10;
    end
  end

  always_comb begin
    fwd_b = 2'b00;
    if (!rst) begin
      if (e_match_rt && !e_mem_to_reg) fwd_b = 2'b01;
      else if (m_match_rt)             fwd_b = m_mem_to_reg ? 2'b11 : 2'b10;
    end
  end

  assign write_pc_ir = ~stall;
  assign bubble      = stall;
  assign flush_if    = taken & ~stall & ~rst;
  assign mul_busy    = (state == MUL_WAIT) & ~rst;

  // A stalled multiply must not claim the scoreboard; it retries next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      mul_cnt <= '0;
      mul_des <= '0;
    end else begin
      case (state)
        RUN: begin
          if (d_is_mul && !stall) begin
            mul_cnt <= CNT_W'(MUL_LAT - 1);
            mul_des <= d_des;
            state   <= MUL_WAIT;
          end
        end
        MUL_WAIT: begin
          mul_cnt <= mul_cnt - CNT_W'(1);
          if (mul_cnt == CNT_W'(1)) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (rst)                          perf_cnt <= '0;
    else if (stall && perf_cnt != '1) perf_cnt <= perf_cnt + PERF_W'(1);
  end

  assign stall_cycles = perf_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - directed scoreboard bench for pipe_hazard_unit
module tb_pipe_hazard_unit;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] d_rs, d_rt, d_des, e_des, m_des;
  logic       d_use_rs, d_use_rt, d_is_branch, d_branch_ne, rs_rt_equ, d_is_mul;
  logic       e_write_reg, m_write_reg, e_mem_to_reg, m_mem_to_reg;
  logic [1:0] fwd_a, fwd_b;
  logic       write_pc_ir, bubble, flush_if, mul_busy;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       wpi;
    logic       bub;
    logic       fl;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipe_hazard_unit #(.REG_ADDR_W(5), .MUL_LAT(4), .CNT_W(3), .PERF_W(32)) dut (
    .clk(clk), .rst(rst),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .d_is_branch(d_is_branch), .d_branch_ne(d_branch_ne), .rs_rt_equ(rs_rt_equ),
    .d_is_mul(d_is_mul), .d_des(d_des),
    .e_des(e_des), .m_des(m_des),
    .e_write_reg(e_write_reg), .m_write_reg(m_write_reg),
    .e_mem_to_reg(e_mem_to_reg), .m_mem_to_reg(m_mem_to_reg),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .write_pc_ir(write_pc_ir), .bubble(bubble),
    .flush_if(flush_if), .mul_busy(mul_busy), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    d_rs = 0; d_rt = 0; d_des = 0; e_des = 0; m_des = 0;
    d_use_rs = 0; d_use_rt = 0; d_is_branch = 0; d_branch_ne = 0; rs_rt_equ = 0;
    d_is_mul = 0; e_write_reg = 0; m_write_reg = 0; e_mem_to_reg = 0; m_mem_to_reg = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic expect_o(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                          input logic wpi, input logic bub, input logic fl, input logic busy);
    exp_t e;
    e.tag = tag; e.fa = fa; e.fb = fb; e.wpi = wpi; e.bub = bub; e.fl = fl; e.busy = busy;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.tag, ".fwd_a"},       32'(fwd_a),       32'(e.fa));
      chk({e.tag, ".fwd_b"},       32'(fwd_b),       32'(e.fb));
      chk({e.tag, ".write_pc_ir"}, 32'(write_pc_ir), 32'(e.wpi));
      chk({e.tag, ".bubble"},      32'(bubble),      32'(e.bub));
      chk({e.tag, ".flush_if"},    32'(flush_if),    32'(e.fl));
      chk({e.tag, ".mul_busy"},    32'(mul_busy),    32'(e.busy));
    end
  endtask

  initial begin
    rst = 1'b1;
    clr();

    // reset forces idle outputs even with hazards present
    tick(); rst = 1;
    e_des = 3; e_write_reg = 1; d_rs = 3; d_use_rs = 1; d_is_branch = 1; rs_rt_equ = 1;
    expect_o("reset", 2'b00, 2'b00, 1, 0, 0, 0); sample();
    chk("reset.stall_cycles", stall_cycles, 0);

    tick(); rst = 0;
    e_des = 3; e_write_reg = 1; m_des = 3; m_write_reg = 1; d_rs = 3; d_use_rs = 1;
    expect_o("exe_fwd", 2'b01, 2'b00, 1, 0, 0, 0); sample();

    tick(); m_des = 4; m_write_reg = 1; d_rt = 4; d_use_rt = 1;
    expect_o("mem_alu_fwd", 2'b00, 2'b10, 1, 0, 0, 0); sample();

    tick(); e_des = 5; e_write_reg = 1; e_mem_to_reg = 1; d_rt = 5; d_use_rt = 1; d_des = 6;
    expect_o("load_use", 2'b00, 2'b00, 0, 1, 0, 0); sample();
    tick(); m_des = 5; m_write_reg = 1; m_mem_to_reg = 1; d_rt = 5; d_use_rt = 1; d_des = 6;
    expect_o("load_fwd", 2'b00, 2'b11, 1, 0, 0, 0); sample();

    tick(); e_des = 0; e_write_reg = 1; e_mem_to_reg = 1; m_write_reg = 1; d_rs = 0; d_use_rs = 1;
    expect_o("reg0_guard", 2'b00, 2'b00, 1, 0, 0, 0); sample();

    tick(); e_des = 6; e_write_reg = 1; e_mem_to_reg = 1; d_rs = 6; d_use_rs = 0;
    expect_o("unused_src", 2'b00, 2'b00, 1, 0, 0, 0); sample();

    tick(); d_is_branch = 1; d_branch_ne = 0; rs_rt_equ = 1;
    expect_o("beq_taken", 2'b00, 2'b00, 1, 0, 1, 0); sample();
    tick(); d_is_branch = 1; d_branch_ne = 1; rs_rt_equ = 1;
    expect_o("bne_not_taken", 2'b00, 2'b00, 1, 0, 0, 0); sample();
    tick(); d_is_branch = 1; d_branch_ne = 1; rs_rt_equ = 0;
    expect_o("bne_taken", 2'b00, 2'b00, 1, 0, 1, 0); sample();

    tick(); d_is_branch = 1; rs_rt_equ = 1; d_rs = 8; d_use_rs = 1; e_des = 8; e_write_reg = 1;
    expect_o("br_dep", 2'b01, 2'b00, 0, 1, 0, 0); sample();
    tick(); d_is_branch = 1; rs_rt_equ = 1; d_rs = 8; d_use_rs = 1; m_des = 8; m_write_reg = 1;
    expect_o("br_after_dep", 2'b10, 2'b00, 1, 0, 1, 0); sample();

    // multiply to r7, dependent reader stalls for cycles 1-3
    tick(); rst = 1; expect_o("rst2", 2'b00, 2'b00, 1, 0, 0, 0); sample();
    tick(); rst = 0; d_is_mul = 1; d_des = 7;
    expect_o("mul_c0", 2'b00, 2'b00, 1, 0, 0, 0); sample();
    for (int c = 1; c <= 3; c++) begin
      tick(); d_rs = 7; d_use_rs = 1; d_des = 9;
      expect_o($sformatf("mul_reader_c%0d", c), 2'b00, 2'b00, 0, 1, 0, 1); sample();
    end
    tick(); d_rs = 7; d_use_rs = 1; d_des = 9;
    expect_o("mul_reader_c4", 2'b00, 2'b00, 1, 0, 0, 0); sample();
    chk("mul.stall_cycles", stall_cycles, PERF ? 32'd3 : 32'd0);

    // back-to-back multiplies: second waits for cycle 4
    tick(); d_is_mul = 1; d_des = 7;
    expect_o("mul2_c0", 2'b00, 2'b00, 1, 0, 0, 0); sample();
    for (int c = 1; c <= 3; c++) begin
      tick(); d_is_mul = 1; d_des = 10;
      expect_o($sformatf("mul2_wait_c%0d", c), 2'b00, 2'b00, 0, 1, 0, 1); sample();
    end
    tick(); d_is_mul = 1; d_des = 10;
    expect_o("mul2_accept", 2'b00, 2'b00, 1, 0, 0, 0); sample();
    tick();
    expect_o("mul2_busy", 2'b00, 2'b00, 1, 0, 0, 1); sample();

    // reset mid-multiply abandons the r10 entry
    tick(); rst = 1; d_rs = 10; d_use_rs = 1;
    expect_o("mid_rst", 2'b00, 2'b00, 1, 0, 0, 0); sample();
    tick(); rst = 0; d_rs = 10; d_use_rs = 1;
    expect_o("after_rst", 2'b00, 2'b00, 1, 0, 0, 0); sample();
    chk("after_rst.stall_cycles", stall_cycles, 0);

    // write-after-write and stall-beats-flush while the multiplier is busy
    tick(); d_is_mul = 1; d_des = 11;
    expect_o("mul3_c0", 2'b00, 2'b00, 1, 0, 0, 0); sample();
    tick(); d_des = 11;
    expect_o("waw", 2'b00, 2'b00, 0, 1, 0, 1); sample();
    tick(); d_is_branch = 1; rs_rt_equ = 1; d_rs = 11; d_use_rs = 1;
    expect_o("stall_over_flush", 2'b00, 2'b00, 0, 1, 0, 1); sample();
    tick();
    expect_o("mul3_c3", 2'b00, 2'b00, 1, 0, 0, 1); sample();
    tick(); d_is_branch = 1; rs_rt_equ = 1; d_rs = 11; d_use_rs = 1;
    expect_o("mul3_done_flush", 2'b00, 2'b00, 1, 0, 1, 0); sample();
    chk("final.stall_cycles", stall_cycles, PERF ? 32'd2 : 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
